// File: rtl/demux_1x3.sv
// demux_1x3
// Registered 1-to-3 demultiplexer with a valid/ready handshake on the input
// side and on each of the three output channels. Every channel owns a
// one-entry holding register, so the three consumers stall and drain
// independently of one another.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_data, in_sel, in_valid     producer word, destination select, offer
//   in_ready                      block accepts this cycle (combinational)
//   outK_data, outK_valid         holding register K contents / full flag
//   outK_ready                    consumer K takes the word this cycle
//   drop_count                    saturating count of accepted sel = 11 words
//
// Select encoding matches the 3:1 select mux:
//   00 -> ch1, 01 -> ch2, 10 -> ch3, 11 -> discarded and counted.
module demux_1x3 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  output logic [CNT_W-1:0] drop_count
);

  logic [WIDTH-1:0] chanData [3];
  logic [2:0]       chanValid;
  logic [2:0]       chanReady;
  logic [2:0]       chanFree;
  logic [2:0]       chanLoad;
  logic             inTransfer;
  logic             dropTransfer;

  assign chanReady = {out3_ready, out2_ready, out1_ready};

  // A channel can take a new word when it is empty, or when its current word
  // leaves on this same edge (pass-through at full throughput).
  assign chanFree = ~chanValid | chanReady;

  // in_ready looks only at the channel the select points to. It depends on
  // in_sel even while in_valid is low, and it is intentionally not gated by rst.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'b00:   in_ready = chanFree[0];
      2'b01:   in_ready = chanFree[1];
      2'b10:   in_ready = chanFree[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign inTransfer   = in_valid && in_ready;
  assign dropTransfer = inTransfer && (in_sel == 2'b11);

  always_comb begin
    chanLoad = 3'b000;
    for (int k = 0; k < 3; k++) begin
      chanLoad[k] = inTransfer && (in_sel == 2'(k));
    end
  end

  // A load takes priority over a drain, which is what keeps valid high during
  // a simultaneous load and drain. A drain alone leaves the stale data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      chanValid <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        chanData[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (chanLoad[k]) begin
          chanData[k]  <= in_data;
          chanValid[k] <= 1'b1;
        end else if (chanValid[k] && chanReady[k]) begin
          chanValid[k] <= 1'b0;
        end
      end
    end
  end

  // The drop counter stops at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (dropTransfer && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign out1_data  = chanData[0];
  assign out2_data  = chanData[1];
  assign out3_data  = chanData[2];
  assign out1_valid = chanValid[0];
  assign out2_valid = chanValid[1];
  assign out3_valid = chanValid[2];

endmodule

// File: doc/demux_1x3.md
# demux_1x3

Registered 1-to-3 demultiplexer with per-output valid/ready handshake. It accepts a data word plus a 2-bit channel select and delivers the word on exactly one of three output channels through a one-entry holding register. It is the distribution-side counterpart of the 3:1 select mux, so the 2-bit encoding is identical: 00 selects channel 1, 01 selects channel 2, 10 selects channel 3. Selector 11 is discarded and counted. It sits between a producer stage (e.g. ALU/memory result) and three independent consumer stages that can stall.

## Interface
- WIDTH, 32, data width of input and each output channel
- CNT_W, 8, width of the saturating drop counter

- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination: 00 = ch1, 01 = ch2, 10 = ch3, 11 = invalid/drop
- in_valid  input  1  producer offers in_data/in_sel this cycle
- in_ready  output  1  block accepts this cycle (combinational)
- out1_data / out2_data / out3_data  output  WIDTH each  holding-register contents
- out1_valid / out2_valid / out3_valid  output  1 each  holding register k is full
- out1_ready / out2_ready / out3_ready  input  1 each  consumer k takes the word this cycle
- drop_count  output  CNT_W  number of accepted words with in_sel = 11, saturating

## Operation
- Input transfer: in_valid && in_ready at a rising clk edge.
- Output transfer on channel k: outk_valid && outk_ready at a rising clk edge.
- in_ready per in_sel:
  - sel 00/01/10: in_ready = !outk_valid || outk_ready for the selected k only. The state of the other channels is irrelevant.
  - sel 11: in_ready = 1.
- in_ready depends on in_sel even when in_valid = 0.
- Channel k register, per cycle, in priority order:
  - rst: outk_valid <= 0, outk_data <= 0.
  - Input transfer targeting k: outk_data <= in_data, outk_valid <= 1. This covers a simultaneous output transfer on k, which gives a full-throughput pass-through.
  - Output transfer on k with no load: outk_valid <= 0. outk_data holds its old value.
  - Otherwise: hold.
- Exactly one channel is loaded per input transfer. Channels drain independently and concurrently.
- Drop path: an input transfer with in_sel = 11 loads no channel. drop_count <= drop_count + 1, saturating at all-ones (2^CNT_W − 1) with no wrap.
- Ordering: words sent to the same channel leave in acceptance order. No ordering is defined across channels.
- Producer rule: once in_valid = 1 and in_ready = 0, in_data and in_sel stay stable until transfer. The block does not check this rule.
- Consumer rule: outk_data/outk_valid are registers and change only at clk edges.

## Timing
- Reset values: every outk_valid = 0, every outk_data = 0, drop_count = 0.
  - in_ready after reset = 1 for any in_sel.
- Latency: a word accepted at edge N shows on outk_data with outk_valid = 1 after edge N. It is consumable at edge N+1.
- Throughput: 1 word/cycle per channel when the consumer holds outk_ready = 1.
- Full channel k with outk_ready = 0: in_ready = 0 for sel = k. The producer stalls. Other channels keep draining.
- Reset mid-operation: rst wins over any simultaneous load or drain.
  - All held words are discarded and drop_count is cleared on that edge.
  - in_ready is not gated by rst.
  - Any transfer presented in the reset cycle is lost.
- Saturation: at drop_count = 2^CNT_W − 1, further sel-11 transfers still complete (in_ready = 1) and the count holds.
- No combinational path from in_valid to any output. The in_sel → in_ready and outk_ready → in_ready paths are combinational.

## Test plan
- Reset/basic route:
  - Stimulus: after rst, in_data = 0xDEADBEEF, sel = 01, valid for 1 cycle, all outk_ready = 0.
  - Required: out2_valid = 1 and out2_data = 0xDEADBEEF the next cycle; out1_valid = out3_valid = 0; in_ready with sel = 01 drops to 0.
- Back-pressure isolation:
  - Stimulus: fill ch1 (sel 00, out1_ready = 0), then present 0x3 on sel 10.
  - Required: in_ready = 0 for sel 00 but 1 for sel 10; out3_data = 0x3 a cycle later; out1_data is unchanged.
- Pass-through streaming:
  - Stimulus: out3_ready = 1, feed 0x10..0x17 on sel 10 on consecutive cycles.
  - Required: in_ready stays 1; out3 delivers 0x10..0x17 in order, one per cycle; out3_valid stays 1 for 8 cycles.
- Drop counting and saturation:
  - Stimulus: CNT_W = 8, send 300 transfers with sel = 11.
  - Required: no outk_valid ever asserts; drop_count reaches 255 and holds; in_ready = 1 throughout.
- Simultaneous load/drain:
  - Stimulus: ch1 holds 0xA. In the same cycle out1_ready = 1 and 0xB arrives on sel 00.
  - Required: out1_valid stays 1; out1_data = 0xB; 0xA is counted as consumed exactly once.
- Reset mid-operation:
  - Stimulus: all three channels full, drop_count = 5; assert rst for 1 cycle together with in_valid, sel 00.
  - Required: all outk_valid = 0, all outk_data = 0, drop_count = 0 after that edge; the concurrent input is not loaded.
